// File: rtl/lmg_drain_ctrl.sv
// Drains the legal-move generator FIFO into RAM: one 18-bit move per word,
// followed by a move-count header and a zero terminator word.
`timescale 1ns/1ps
module lmg_drain_ctrl #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned BASE_ADDR  = 16,
    parameter int unsigned MAX_MOVES  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7:0]            move_count,
    output logic                  lmg_reset,
    input  logic                  lmg_done,
    output logic                  lmg_rden,
    input  logic [151:0]          lmg_fifo_out,
    input  logic                  lmg_fifo_empty,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddr,
    output logic [31:0]           ram_wdata
);

    localparam int unsigned SLOT_W = 19;
    localparam int unsigned WORD_W = 152;

    typedef enum logic [3:0] {
        IDLE, LRST, WAIT, POP, LATCH, SCAN, HDR, TERM, DONE
    } state_t;

    state_t              state;
    logic [2:0]          cnt;
    logic [WORD_W-1:0]   wordReg;
    logic [2:0]          slotIdx;
    logic [SLOT_W-1:0]   nextSlot;
    logic                slotDue;
    logic [ADDR_WIDTH-1:0] moveAddr;

    // The slot shown during the coming SCAN cycle; slot 0 comes straight off
    // the FIFO so its write lands in the first SCAN cycle.
    always_comb begin
        slotIdx  = 3'(cnt + 3'd1);
        nextSlot = wordReg[SLOT_W*32'(slotIdx) +: SLOT_W];
        if (state == LATCH) begin
            nextSlot = lmg_fifo_out[SLOT_W-1:0];
        end
        slotDue  = (state == LATCH) || ((state == SCAN) && (cnt != 3'd7));
        moveAddr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(move_count) + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            wordReg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            move_count <= 8'd0;
            lmg_reset  <= 1'b0;
            lmg_rden   <= 1'b0;
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_wdata  <= 32'd0;
        end else begin
            lmg_reset <= 1'b0;
            lmg_rden  <= 1'b0;
            ram_wren  <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state      <= LRST;
                            cnt        <= 3'd0;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            overflow   <= 1'b0;
                            move_count <= 8'd0;
                            lmg_reset  <= 1'b1;
                        end
                    end
                    LRST: begin
                        if (cnt == 3'd0) begin
                            cnt       <= 3'd1;
                            lmg_reset <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (lmg_done) begin
                            if (lmg_fifo_empty) begin
                                state      <= HDR;
                                ram_wren   <= 1'b1;
                                ram_wraddr <= ADDR_WIDTH'(BASE_ADDR);
                                ram_wdata  <= 32'(move_count);
                            end else begin
                                state    <= POP;
                                lmg_rden <= 1'b1;
                            end
                        end
                    end
                    POP: state <= LATCH;
                    LATCH: begin
                        wordReg <= lmg_fifo_out;
                        cnt     <= 3'd0;
                        state   <= SCAN;
                    end
                    SCAN: begin
                        if (cnt == 3'd7) begin
                            if (lmg_fifo_empty) begin
                                state      <= HDR;
                                ram_wren   <= 1'b1;
                                ram_wraddr <= ADDR_WIDTH'(BASE_ADDR);
                                ram_wdata  <= 32'(move_count);
                            end else begin
                                state    <= POP;
                                lmg_rden <= 1'b1;
                            end
                        end else begin
                            cnt <= slotIdx;
                        end
                    end
                    HDR: begin
                        state      <= TERM;
                        ram_wren   <= 1'b1;
                        ram_wraddr <= moveAddr;
                        ram_wdata  <= 32'd0;
                    end
                    TERM: begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase

                // Store a valid move, or flag it as dropped once the table is full
                if (slotDue && !nextSlot[SLOT_W-1]) begin
                    if (move_count < 8'(MAX_MOVES)) begin
                        ram_wren   <= 1'b1;
                        ram_wraddr <= moveAddr;
                        ram_wdata  <= {14'b0, nextSlot[SLOT_W-2:0]};
                        move_count <= 8'(move_count + 8'd1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
